// File: rtl/count_seq_if.sv
// Host and downcounter signals of the countdown sequencer.
// The slave modport is the sequencer's view; the master modport is the host and counter's view.
interface count_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] count_in;
    logic             step;
    logic             abort;
    logic             ctr_zero;
    logic [WIDTH-1:0] ctr_in;
    logic             ctr_latch;
    logic             ctr_dec;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH-1:0] elapsed;

    modport slave (
        input  start, count_in, step, abort, ctr_zero,
        output ctr_in, ctr_latch, ctr_dec, busy, done, aborted, elapsed
    );

    modport master (
        output start, count_in, step, abort, ctr_zero,
        input  ctr_in, ctr_latch, ctr_dec, busy, done, aborted, elapsed
    );
endinterface

// File: rtl/count_seq.sv
// Countdown sequencer: loads an external downcounter, issues decrement strobes on host permission,
// and reports normal completion or abort together with the number of decrements issued.
module count_seq #(
    parameter int WIDTH = 4
) (
    input logic        clock,
    input logic        reset,
    count_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, CLR} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] ctr_in_q;
    logic [WIDTH-1:0] elapsed_q;
    logic             dec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (bus.start) nxt = LOAD;
            LOAD: nxt = bus.abort ? CLR : RUN;
            RUN: begin
                if (bus.abort) begin
                    nxt = CLR;
                end else if (bus.ctr_zero) begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = IDLE;
            CLR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dec           = (state == RUN) & bus.step & ~bus.ctr_zero & ~bus.abort;
        bus.ctr_dec   = dec;
        bus.ctr_latch = (state == LOAD) || (state == CLR);
        bus.busy      = (state == LOAD) || (state == RUN);
        bus.done      = (state == DONE);
        bus.aborted   = (state == CLR);
        bus.ctr_in    = ctr_in_q;
        bus.elapsed   = elapsed_q;
    end

    // ctr_in is zeroed on entry to CLR so the clearing latch loads zero into the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctr_in_q  <= '0;
            elapsed_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                ctr_in_q  <= bus.count_in;
            end else if ((state == LOAD || state == RUN) && bus.abort) begin
                ctr_in_q  <= '0;
            end
            if (state == IDLE && bus.start) begin
                elapsed_q <= '0;
            end else if (dec && elapsed_q != '1) begin
                elapsed_q <= elapsed_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_seq.sv
// Scoreboard bench for count_seq with a behavioural downcounter attached.
// Stimulus queues the expected completion; a forked monitor checks each done/aborted pulse.
module tb_count_seq;

    localparam int W = 4;

    typedef struct {
        bit         ab;
        logic [W-1:0] el;
        int         cyc;
        int         decs;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] cnt;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           dec_total = 0;
    int           t_edge = 0;
    exp_t         q[$];

    count_seq_if #(.WIDTH(W)) bus ();

    count_seq #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.ctr_latch) begin
            cnt <= bus.ctr_in;
        end else if (bus.ctr_dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bus.ctr_zero = (cnt == '0);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // lat is the cycle index of the done/aborted pulse, cycle 1 being LOAD.
    task automatic go(input int n, input bit push, input bit ab, input int el, input int lat,
                      input int decs);
        exp_t e;
        bus.start    = 1'b1;
        bus.count_in = W'(n);
        t_edge       = cyc + 1;
        if (push) begin
            e.ab   = ab;
            e.el   = W'(el);
            e.cyc  = t_edge + lat - 1;
            e.decs = dec_total + decs;
            q.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        exp_t e;
        bus.start    = 1'b0;
        bus.count_in = '0;
        bus.step     = 1'b0;
        bus.abort    = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_aborted", bus.aborted, 0);
        chk("rst_latch", bus.ctr_latch, 0);
        chk("rst_dec", bus.ctr_dec, 0);
        chk("rst_ctr_in", bus.ctr_in, 0);
        chk("rst_elapsed", bus.elapsed, 0);
        tick();
        tick();
        reset = 1'b0;

        fork
            forever begin
                @(negedge clock);
                if (!reset) begin
                    if (bus.ctr_dec) dec_total++;
                    if (bus.done || bus.aborted) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_pulse: got done=%0d aborted=%0d expected none",
                                     bus.done, bus.aborted);
                        end else begin
                            e = q.pop_front();
                            chk("kind_aborted", bus.aborted, e.ab);
                            chk("kind_done", bus.done, !e.ab);
                            chk("elapsed", bus.elapsed, e.el);
                            chk("pulse_cycle", cyc, e.cyc);
                            chk("dec_count", dec_total, e.decs);
                            if (e.ab) begin
                                chk("clr_ctr_in", bus.ctr_in, 0);
                                chk("clr_latch", bus.ctr_latch, 1);
                            end
                        end
                    end
                end
            end
            begin
                bus.abort = 1'b1;
                repeat (3) tick();
                chk("idle_abort_busy", bus.busy, 0);
                bus.abort = 1'b0;

                bus.step = 1'b1;
                go(5, 1, 0, 5, 8, 5);
                drain();
                chk("hold_ctr_in", bus.ctr_in, 5);
                chk("hold_elapsed", bus.elapsed, 5);

                go(0, 1, 0, 0, 3, 0);
                drain();

                bus.step = 1'b0;
                go(4, 1, 0, 4, 10, 4);
                for (int c = 2; c <= 12; c++) begin
                    tick();
                    bus.step = (c % 2 == 0);
                end
                drain();

                bus.step = 1'b1;
                go(9, 1, 1, 3, 6, 3);
                repeat (4) tick();
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                drain();
                chk("abort_hold_elapsed", bus.elapsed, 3);

                go(6, 1, 1, 0, 2, 0);
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                drain();

                go(5, 1, 0, 5, 8, 5);
                repeat (2) tick();
                bus.start    = 1'b1;
                bus.count_in = 4'd3;
                repeat (2) tick();
                chk("midrun_ctr_in", bus.ctr_in, 5);
                chk("midrun_busy", bus.busy, 1);
                repeat (4) tick();
                bus.start = 1'b0;
                drain();
                chk("start_in_done_ignored", bus.busy, 0);
                chk("after_ignore_ctr_in", bus.ctr_in, 5);

                go(15, 1, 0, 15, 18, 15);
                drain();

                go(9, 0, 0, 0, 0, 0);
                repeat (3) tick();
                #2 reset = 1'b1;
                #1;
                chk("async_busy", bus.busy, 0);
                chk("async_dec", bus.ctr_dec, 0);
                chk("async_latch", bus.ctr_latch, 0);
                chk("async_ctr_in", bus.ctr_in, 0);
                chk("async_elapsed", bus.elapsed, 0);
                tick();
                tick();
                reset = 1'b0;
                tick();
                chk("post_reset_idle", bus.busy, 0);
                go(3, 1, 0, 3, 6, 3);
                drain();
            end
        join_any

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_seq.md
COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 Parameter: WIDTH, default 4, width of the load value, ctr_in and elapsed.
REQ-002 Single clock domain; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  host request to begin a countdown; sampled only in IDLE.
REQ-006 count_in  input  WIDTH  countdown length; sampled with start.
REQ-007 step  input  1  host permission to decrement this cycle.
REQ-008 abort  input  1  host cancel; honoured only in LOAD or RUN.
REQ-009 ctr_zero  input  1  zero flag from the attached downcounter.
REQ-010 ctr_in  output  WIDTH  load value presented to the downcounter.
REQ-011 ctr_latch  output  1  load strobe to the downcounter.
REQ-012 ctr_dec  output  1  decrement strobe to the downcounter.
REQ-013 busy  output  1  high while in LOAD or RUN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 aborted  output  1  one-cycle pulse on abort completion.
REQ-016 elapsed  output  WIDTH  number of ctr_dec strobes issued in the current or last run.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, DONE and CLR.
REQ-018 IDLE, start=1: next state LOAD; ctr_in <= count_in; elapsed <= 0; start=0: stay in IDLE.
REQ-019 LOAD SHALL last exactly one cycle, with ctr_latch=1, then go to RUN, unless abort=1, which goes to CLR.
REQ-020 ctr_latch SHALL be high only in LOAD and CLR, decoded from the state register.
REQ-021 RUN: abort=1 -> CLR (priority); else ctr_zero=1 -> DONE; else stay in RUN.
REQ-022 ctr_dec SHALL equal (state==RUN) & step & ~ctr_zero & ~abort (combinational), so no decrement is issued at zero.
REQ-023 elapsed SHALL increment by 1 on every cycle with ctr_dec=1 and saturate at 2^WIDTH-1.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; start in DONE is ignored.
REQ-025 CLR SHALL last one cycle with ctr_latch=1, ctr_in=0 and aborted=1, then go to IDLE.
REQ-026 start SHALL be ignored in all states except IDLE; abort SHALL be ignored in IDLE, DONE and CLR.
REQ-027 count_in=0 SHALL complete through LOAD, RUN, DONE with elapsed=0 and no ctr_dec.
REQ-028 With step held high and count_in=N, done SHALL be high in cycle N+3 after the start-sampling edge, and elapsed SHALL be N.
REQ-029 step low in RUN SHALL stall with no state change; gaps extend the latency one cycle each.
REQ-030 ctr_in SHALL hold its value between loads; elapsed SHALL hold after DONE or CLR until the next start.

Reset
REQ-031 reset=1 SHALL immediately force: state IDLE; ctr_in, elapsed = 0; ctr_latch, ctr_dec, busy, done, aborted = 0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done or aborted pulse; the first cycle after release is IDLE.

Verification
REQ-033 start, count_in=5, step=1 held, counter model attached -> LOAD, 5 ctr_dec pulses, done in cycle 8, elapsed=5.
REQ-034 start, count_in=0 -> done in cycle 3, no ctr_dec, elapsed=0.
REQ-035 count_in=4, step toggled 1,0,1,0... -> 4 ctr_dec, done delayed by 3 cycles versus step held, elapsed=4.
REQ-036 count_in=9, abort after 3 decrements -> CLR cycle with ctr_latch=1, ctr_in=0, aborted=1, no done, elapsed=3.
REQ-037 start pulsed during RUN and DONE -> ignored; count_in changes mid-run -> ctr_in unchanged.
REQ-038 Asynchronous reset mid-RUN (between clock edges) -> outputs zero immediately; start after release runs normally.
